// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin arbitration.
// Each operation takes IDLE -> EXEC -> RESP. The response is held until the owner accepts it.
module alu_share_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [OP_WIDTH-1:0]   req0_op,
  output logic                  resp0_valid,
  input  logic                  resp0_ready,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic [OP_WIDTH-1:0]   req1_op,
  output logic                  resp1_valid,
  input  logic                  resp1_ready,
  output logic [DATA_WIDTH-1:0] resp_result,
  output logic                  resp_zero,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] alu_src_a,
  output logic [DATA_WIDTH-1:0] alu_src_b,
  output logic [OP_WIDTH-1:0]   alu_op,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [OP_WIDTH-1:0]   op_q;
  logic                  owner_q;
  logic                  last_grant_q;
  logic                  grant1;
  logic                  req_fire;
  logic                  resp_fire;
  logic                  op_legal;

  // Round-robin pick: under contention the requester not served last wins.
  always_comb begin
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant1 = ~last_grant_q;
    end else begin
      grant1 = req1_valid;
    end
    req0_ready = (state_q == IDLE) && req0_valid && !grant1;
    req1_ready = (state_q == IDLE) && req1_valid && grant1;
    req_fire   = req0_ready || req1_ready;
    resp_fire  = (state_q == RESP) && (owner_q ? resp1_ready : resp0_ready);
  end

  // Legal opcode decode; illegal codes still run but are flagged.
  always_comb begin
    op_legal = 1'b0;
    case (op_q)
      OP_WIDTH'(4'h0), OP_WIDTH'(4'h1), OP_WIDTH'(4'h2),
      OP_WIDTH'(4'h6), OP_WIDTH'(4'h7), OP_WIDTH'(4'h8),
      OP_WIDTH'(4'h9), OP_WIDTH'(4'ha), OP_WIDTH'(4'hf): op_legal = 1'b1;
      default:                                           op_legal = 1'b0;
    endcase
  end

  // Next-state logic and state-derived outputs.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_fire) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (resp_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy        = (state_q != IDLE);
    resp0_valid = (state_q == RESP) && !owner_q;
    resp1_valid = (state_q == RESP) && owner_q;
    alu_src_a   = a_q;
    alu_src_b   = b_q;
    alu_op      = op_q;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand latch, owner tracking and round-robin history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (req_fire) begin
      a_q          <= grant1 ? req1_a : req0_a;
      b_q          <= grant1 ? req1_b : req0_b;
      op_q         <= grant1 ? req1_op : req0_op;
      owner_q      <= grant1;
      last_grant_q <= grant1;
    end
  end

  // Capture the ALU response at the end of EXEC and hold it through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_err    <= 1'b0;
    end else if (state_q == EXEC) begin
      resp_result <= alu_result;
      resp_zero   <= alu_zero;
      resp_err    <= !op_legal;
    end
  end

  // Saturating completion counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_done <= '0;
    end else if (resp_fire && (ops_done != {CNT_WIDTH{1'b1}})) begin
      ops_done <= ops_done + CNT_WIDTH'(1);
    end
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one combinational ALU between two requesters, requester 0 (execute stage) and requester 1 (address/branch helper).
Each requester uses a valid/ready handshake for operands and another for the response.
The block arbitrates round-robin, registers the operands, drives the ALU for one cycle, captures the result and zero flag, and holds the response until it is accepted.
It also flags illegal opcodes and counts completed operations.

Parameters:
DATA_WIDTH, 32, operand/result width
OP_WIDTH, 4, ALU opcode width
CNT_WIDTH, 16, width of the completed-operation counter

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  DATA_WIDTH  requester 0 operand A
req0_b  in  DATA_WIDTH  requester 0 operand B
req0_op  in  OP_WIDTH  requester 0 ALU opcode
resp0_valid  out  1  response for requester 0 available
resp0_ready  in  1  requester 0 takes the response
req1_valid, req1_ready, req1_a, req1_b, req1_op, resp1_valid, resp1_ready  same as for requester 0
resp_result  out  DATA_WIDTH  captured ALU result (shared by both responders)
resp_zero  out  1  captured ALU zero flag
resp_err  out  1  opcode was not a legal ALU code
alu_src_a  out  DATA_WIDTH  to ALU src_a
alu_src_b  out  DATA_WIDTH  to ALU src_b
alu_op  out  OP_WIDTH  to ALU alu_op
alu_result  in  DATA_WIDTH  from ALU result
alu_zero  in  1  from ALU zero
busy  out  1  high whenever the state is not IDLE
ops_done  out  CNT_WIDTH  count of completed responses, saturating

Behaviour:
- States: IDLE, EXEC, RESP. Reset puts the block in IDLE.
- Reset values:
  - resp0_valid = resp1_valid = 0, resp_result = 0, resp_zero = 0, resp_err = 0.
  - Operand registers = 0, alu_* outputs = 0, busy = 0, ops_done = 0.
  - Internal owner = 0; last_grant = 1, so requester 0 wins the first contention.
- IDLE, arbitration (combinational):
  - Only req0_valid high: grant 0. Only req1_valid high: grant 1.
  - Both high: grant the requester that is not last_grant.
  - req0_ready / req1_ready are high only in IDLE, only for the granted requester, and only while that requester's valid is high. At most one ready is high per cycle.
- IDLE, on handshake (reqX_valid & reqX_ready):
  - Latch a, b, op and owner = X; set last_grant = X; go to EXEC.
- EXEC (exactly 1 cycle):
  - alu_src_a, alu_src_b, alu_op are driven from the latched registers.
  - At the end of the cycle, capture resp_result = alu_result and resp_zero = alu_zero.
  - resp_err = 1 if op is not one of 0000, 0001, 0010, 0110, 0111, 1000, 1001, 1010, 1111.
  - Go to RESP.
- Outside EXEC the alu_* outputs hold the last latched values; they are don't-care for the ALU.
- RESP:
  - resp{owner}_valid = 1; the other resp valid = 0.
  - resp_result, resp_zero, resp_err are stable until the handshake.
  - On resp{owner}_ready: go to IDLE, clear the valid, and increment ops_done unless it is all-ones.
  - A ready from the non-owner is ignored.
- Latency: request handshake in cycle N -> response valid in cycle N+2. Minimum repeat interval is 3 cycles per operation.
- Illegal opcode: still executed (the ALU returns 0). resp_err = 1 and resp_zero reflects the ALU's zero flag (1).
- A request dropped before its handshake leaves no state change. Requesters must hold a, b, op stable while valid && !ready.
- Reset asserted mid-operation (EXEC or RESP): immediately return to IDLE with all reset values. A pending response is discarded and not counted.
- Simultaneous reqX_valid and a pending response: no new request is accepted until the state returns to IDLE.

Test Plan:
- Single op: req0 a=5, b=3, op=0010 → req0_ready in cycle N; resp0_valid in N+2 with result=8, zero=0, err=0; ops_done=1 after resp0_ready.
- Contention from reset: req0 and req1 both valid, req0 op=0110 a=b=7, req1 op=0000 → requester 0 served first (result=0, zero=1); requester 1 served next. Repeating the contention alternates 1, 0, 1.
- Backpressure: resp1_ready held low for 10 cycles → resp1_valid and the result stay stable, req0_ready stays 0, busy=1 throughout; completion occurs on the cycle after ready rises.
- Illegal op: op=0011 → resp_err=1, resp_result=0, resp_zero=1. Signed compare: a=0xFFFFFFFF, b=1, op=0111 → result=1. Unsigned compare: same operands, op=1111 → result=0.
- Reset mid-operation: assert rst during EXEC → busy=0 and resp0_valid=0 immediately, ops_done=0; the next contention grants requester 0 first.
- Counter saturation with CNT_WIDTH=2: five completed ops → ops_done sticks at 3.
